uart_rx: RTL and testbench

//  Receive side of the UART: deserialises the rx line into 5-8 bit words, using the same
//  cfg_* frame settings as the transmitter (div, parity, bits, stop bits).
//  2-flop synchroniser, mid-bit sampling, even-parity and stop-bit checking.

---
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, samples each bit at its mid-point and
// hands completed 5-8 bit words to the consumer through a one-entry valid/ready register.
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        busy_o,
    output logic        err_parity_o,
    output logic        err_frame_o,
    output logic        err_overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    state_t                 r_state;
    logic [15:0]            r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_stop2;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_err_par;
    logic                   r_err_frm;
    logic                   r_err_ovr;

    logic                   w_rxs;
    logic [15:0]            w_half;
    logic [15:0]            w_target;
    logic                   w_tick;
    logic [2:0]             w_last_idx;
    state_t                 w_state_next;
    logic [15:0]            w_cnt_next;
    logic [2:0]             w_bit_idx_next;
    logic [7:0]             w_shift_next;
    logic                   w_perr_next;
    logic                   w_ferr_next;
    logic                   w_stop2_next;
    logic                   w_done;
    logic                   w_done_ferr;

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    // Start-bit wait is (div+1)>>1 cycles; the counter starts at 0, so the target is one less.
    assign w_half     = {1'b0, cfg_div_i[15:1]} + {15'd0, cfg_div_i[0]} - 16'd1;
    assign w_target   = (r_state == S_START) ? w_half : cfg_div_i;
    assign w_tick     = (r_cnt == w_target);
    assign w_last_idx = 3'd4 + {1'b0, cfg_bits_i};

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_tick ? 16'd0 : r_cnt + 16'd1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_perr_next    = r_perr;
        w_ferr_next    = r_ferr;
        w_stop2_next   = r_stop2;
        w_done         = 1'b0;
        w_done_ferr    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = 16'd0;
                if (cfg_en_i && r_rxs_d && !w_rxs) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (w_rxs) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = 3'd0;
                        w_shift_next   = 8'd0;
                        w_perr_next    = 1'b0;
                        w_ferr_next    = 1'b0;
                        w_stop2_next   = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_next[r_bit_idx] = w_rxs;
                    if (r_bit_idx == w_last_idx) begin
                        w_state_next = cfg_parity_en_i ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_perr_next  = (^r_shift) ^ w_rxs;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (cfg_stop_bits_i && !r_stop2) begin
                        w_stop2_next = 1'b1;
                        w_ferr_next  = r_ferr | ~w_rxs;
                    end else begin
                        w_done       = 1'b1;
                        w_done_ferr  = r_ferr | ~w_rxs;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Disabling the receiver abandons any partial frame without flagging errors.
        if (!cfg_en_i) begin
            w_state_next = S_IDLE;
            w_cnt_next   = 16'd0;
            w_done       = 1'b0;
            w_done_ferr  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync    <= '1;
            r_rxs_d   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_stop2   <= 1'b0;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_err_par <= 1'b0;
            r_err_frm <= 1'b0;
            r_err_ovr <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rxs_d   <= w_rxs;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_perr    <= w_perr_next;
            r_ferr    <= w_ferr_next;
            r_stop2   <= w_stop2_next;
            r_err_par <= w_done & r_perr;
            r_err_frm <= w_done & w_done_ferr;
            r_err_ovr <= w_done & r_valid & ~rx_ready_i;
            // A finished word loads only if the slot is empty or being drained this cycle.
            if (w_done && (!r_valid || rx_ready_i)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o     = r_data;
    assign rx_valid_o    = r_valid;
    assign busy_o        = (r_state != S_IDLE);
    assign err_parity_o  = r_err_par;
    assign err_frame_o   = r_err_frm;
    assign err_overrun_o = r_err_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives whole frames on rx_i and checks words, handshake and errors.
module tb_uart_rx;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        cfg_en_i;
    logic [15:0] cfg_div_i;
    logic        cfg_parity_en_i;
    logic [1:0]  cfg_bits_i;
    logic        cfg_stop_bits_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        busy_o;
    logic        err_parity_o;
    logic        err_frame_o;
    logic        err_overrun_o;

    int n_cmp = 0;
    int n_mis = 0;

    int         n_vrise = 0;
    int         n_vcyc  = 0;
    int         n_perr  = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    logic [7:0] last_data = 8'd0;
    logic       prev_v = 1'b0;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rx_i            (rx_i),
        .cfg_en_i        (cfg_en_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_bits_i      (cfg_bits_i),
        .cfg_stop_bits_i (cfg_stop_bits_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .busy_o          (busy_o),
        .err_parity_o    (err_parity_o),
        .err_frame_o     (err_frame_o),
        .err_overrun_o   (err_overrun_o)
    );

    always #50 clk_i = ~clk_i;

    // Event counters sampled on the falling edge; error pulses count cycles high.
    always @(negedge clk_i) begin
        if (rx_valid_o) begin
            n_vcyc = n_vcyc + 1;
            last_data = rx_data_o;
            if (!prev_v) n_vrise = n_vrise + 1;
        end
        prev_v = rx_valid_o;
        if (err_parity_o)  n_perr = n_perr + 1;
        if (err_frame_o)   n_ferr = n_ferr + 1;
        if (err_overrun_o) n_ovr  = n_ovr + 1;
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (16) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                              input bit two_stop, input bit stop2_val);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(1'b1);
        if (two_stop) drive_bit(stop2_val);
        rx_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_mis++; $display("FAIL reset_valid got=%b want=0", rx_valid_o); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_mis++; $display("FAIL reset_data got=%h want=00", rx_data_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_cmp++; if ({err_parity_o, err_frame_o, err_overrun_o} !== 3'b000) begin
            n_mis++; $display("FAIL reset_errs got=%b want=000", {err_parity_o, err_frame_o, err_overrun_o});
        end
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        $display("reset: outputs checked");
    endtask

    task automatic test_8n1;
        int bv, bc, be;
        bv = n_vrise; bc = n_vcyc; be = n_perr + n_ferr + n_ovr;
        send_frame(8'hA5, 8, 0, 0, 0, 0);
        n_cmp++; if (last_data !== 8'hA5) begin n_mis++; $display("FAIL 8n1_data got=%h want=a5", last_data); end
        n_cmp++; if (n_vrise - bv !== 1) begin n_mis++; $display("FAIL 8n1_valid_pulses got=%0d want=1", n_vrise - bv); end
        n_cmp++; if (n_vcyc - bc !== 1) begin n_mis++; $display("FAIL 8n1_valid_cycles got=%0d want=1", n_vcyc - bc); end
        n_cmp++; if (n_perr + n_ferr + n_ovr - be !== 0) begin n_mis++; $display("FAIL 8n1_errors got=%0d want=0", n_perr + n_ferr + n_ovr - be); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL 8n1_busy_after got=%b want=0", busy_o); end
        $display("8n1: sent a5 received %h", last_data);
    endtask

    task automatic test_parity;
        int bv, bp;
        cfg_parity_en_i = 1'b1;
        bv = n_vrise; bp = n_perr;
        send_frame(8'h08, 8, 1, 1, 0, 0);
        n_cmp++; if (last_data !== 8'h08) begin n_mis++; $display("FAIL par_good_data got=%h want=08", last_data); end
        n_cmp++; if (n_perr - bp !== 0) begin n_mis++; $display("FAIL par_good_err got=%0d want=0", n_perr - bp); end
        $display("parity ok frame: received %h", last_data);
        bv = n_vrise; bp = n_perr;
        send_frame(8'h08, 8, 1, 0, 0, 0);
        n_cmp++; if (n_perr - bp !== 1) begin n_mis++; $display("FAIL par_bad_err got=%0d want=1", n_perr - bp); end
        n_cmp++; if (n_vrise - bv !== 1) begin n_mis++; $display("FAIL par_bad_delivered got=%0d want=1", n_vrise - bv); end
        $display("parity bad frame: parity pulses %0d", n_perr - bp);
        cfg_parity_en_i = 1'b0;
    endtask

    task automatic test_5bit_2stop;
        int bf;
        cfg_bits_i = 2'b00;
        cfg_stop_bits_i = 1'b1;
        bf = n_ferr;
        send_frame(8'h1F, 5, 0, 0, 1, 1);
        n_cmp++; if (last_data !== 8'h1F) begin n_mis++; $display("FAIL 5b_data got=%h want=1f", last_data); end
        n_cmp++; if (n_ferr - bf !== 0) begin n_mis++; $display("FAIL 5b_good_frame got=%0d want=0", n_ferr - bf); end
        $display("5-bit 2-stop: received %h", last_data);
        bf = n_ferr;
        send_frame(8'h0A, 5, 0, 0, 1, 0);
        n_cmp++; if (n_ferr - bf !== 1) begin n_mis++; $display("FAIL 5b_stop2_low got=%0d want=1", n_ferr - bf); end
        n_cmp++; if (last_data !== 8'h0A) begin n_mis++; $display("FAIL 5b_err_data got=%h want=0a", last_data); end
        $display("5-bit stop2 low: frame pulses %0d", n_ferr - bf);
        cfg_bits_i = 2'b11;
        cfg_stop_bits_i = 1'b0;
    endtask

    task automatic test_glitch;
        int bv, be;
        bv = n_vrise; be = n_perr + n_ferr + n_ovr;
        rx_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rx_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL glitch_busy got=%b want=1", busy_o); end
        repeat (40) @(posedge clk_i);
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL glitch_idle got=%b want=0", busy_o); end
        n_cmp++; if (n_vrise - bv !== 0) begin n_mis++; $display("FAIL glitch_valid got=%0d want=0", n_vrise - bv); end
        n_cmp++; if (n_perr + n_ferr + n_ovr - be !== 0) begin n_mis++; $display("FAIL glitch_errs got=%0d want=0", n_perr + n_ferr + n_ovr - be); end
        $display("glitch: 4-clk low pulse ignored");
    endtask

    task automatic test_overrun;
        int bv, bo;
        rx_ready_i = 1'b0;
        bv = n_vrise; bo = n_ovr;
        send_frame(8'h11, 8, 0, 0, 0, 0);
        send_frame(8'h22, 8, 0, 0, 0, 0);
        n_cmp++; if (rx_valid_o !== 1'b1) begin n_mis++; $display("FAIL ovr_valid got=%b want=1", rx_valid_o); end
        n_cmp++; if (rx_data_o !== 8'h11) begin n_mis++; $display("FAIL ovr_data got=%h want=11", rx_data_o); end
        n_cmp++; if (n_ovr - bo !== 1) begin n_mis++; $display("FAIL ovr_pulse got=%0d want=1", n_ovr - bo); end
        n_cmp++; if (n_vrise - bv !== 1) begin n_mis++; $display("FAIL ovr_valid_rises got=%0d want=1", n_vrise - bv); end
        @(negedge clk_i);
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_mis++; $display("FAIL ovr_drain got=%b want=0", rx_valid_o); end
        $display("overrun: kept %h, overrun pulses %0d", rx_data_o, n_ovr - bo);
    endtask

    task automatic test_disable;
        int bv, be;
        rx_i = 1'b0;
        repeat (36) @(posedge clk_i);
        #1;
        n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL dis_busy_before got=%b want=1", busy_o); end
        bv = n_vrise; be = n_perr + n_ferr + n_ovr;
        cfg_en_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL dis_busy_after got=%b want=0", busy_o); end
        rx_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1 cfg_en_i = 1'b1;
        repeat (200) @(posedge clk_i);
        #1;
        n_cmp++; if (n_vrise - bv !== 0 || n_perr + n_ferr + n_ovr - be !== 0) begin
            n_mis++; $display("FAIL dis_side_effects got=%0d/%0d want=0/0", n_vrise - bv, n_perr + n_ferr + n_ovr - be);
        end
        send_frame(8'h5A, 8, 0, 0, 0, 0);
        n_cmp++; if (last_data !== 8'h5A) begin n_mis++; $display("FAIL dis_recover got=%h want=5a", last_data); end
        $display("disable: aborted frame dropped, next received %h", last_data);
    endtask

    task automatic test_reset_midframe;
        int bv;
        rx_ready_i = 1'b0;
        send_frame(8'h55, 8, 0, 0, 0, 0);
        n_cmp++; if (rx_valid_o !== 1'b1) begin n_mis++; $display("FAIL rstm_pending got=%b want=1", rx_valid_o); end
        rx_i = 1'b0;
        repeat (38) @(posedge clk_i);
        #30 rst_i = 1'b1;
        #1;
        n_cmp++; if (rx_valid_o !== 1'b0) begin n_mis++; $display("FAIL rstm_valid got=%b want=0", rx_valid_o); end
        n_cmp++; if (rx_data_o !== 8'h00) begin n_mis++; $display("FAIL rstm_data got=%h want=00", rx_data_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rstm_busy got=%b want=0", busy_o); end
        rx_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        rx_ready_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        bv = n_vrise;
        send_frame(8'h3C, 8, 0, 0, 0, 0);
        n_cmp++; if (last_data !== 8'h3C) begin n_mis++; $display("FAIL rstm_next_data got=%h want=3c", last_data); end
        n_cmp++; if (n_vrise - bv !== 1) begin n_mis++; $display("FAIL rstm_next_valid got=%0d want=1", n_vrise - bv); end
        $display("reset mid-frame: next frame received %h", last_data);
    endtask

    initial begin
        rst_i           = 1'b1;
        rx_i            = 1'b1;
        cfg_en_i        = 1'b1;
        cfg_div_i       = 16'd15;
        cfg_parity_en_i = 1'b0;
        cfg_bits_i      = 2'b11;
        cfg_stop_bits_i = 1'b0;
        rx_ready_i      = 1'b1;
        repeat (3) @(posedge clk_i);
        test_reset;
        test_8n1;
        test_parity;
        test_5bit_2stop;
        test_glitch;
        test_overrun;
        test_disable;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
